barrett_reducer: RTL and testbench

Pipelined Barrett modular reducer that sits directly downstream of the 32x32 Karatsuba multiplier in the NTT butterfly datapath. It accepts the 64-bit product, reduces it modulo a fixed NTT prime Q, and returns the canonical residue in [0, Q). Four register stages with a valid/ready handshake; the whole pipeline stalls under output backpressure.

---
 rtl/barrett_reducer.sv | 118 +++++++++++
 tb/tb_barrett_reducer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrett_reducer.sv
// Four-stage Barrett reducer: 64-bit product in, canonical residue mod Q out.
// Optional input range flag enabled by defining BARRETT_RANGE_CHK_EN.
module barrett_reducer #(
    parameter int wP = 64,
    parameter int Q  = 12289,
    parameter int K  = 14,
    parameter int MU = 21843
) (
    input  logic          iClk,
    input  logic          iRst_n,
    input  logic          iValid,
    output logic          oReady,
    input  logic [wP-1:0] iP,
    output logic          oValid,
    input  logic          iReady,
    output logic [K-1:0]  oR,
    output logic          oRangeErr
);

    localparam int PW = 2 * K;
    localparam int RW = K + 2;

    localparam logic [K:0]    MUL = (K+1)'(MU);
    localparam logic [K-1:0]  QL  = K'(Q);
    localparam logic [RW-1:0] Q1R = RW'(Q);
    localparam logic [RW-1:0] Q2R = RW'(2 * Q);

    logic          en;
    logic          v1, v2, v3, v4;
    logic [RW-1:0] p1, p2;
    logic [K:0]    q1, q3;
    logic [RW-1:0] r3;
    logic [K-1:0]  r4;

    logic [2*K+1:0] q1mu;
    logic [2*K:0]   q3q;
    logic [RW-1:0]  r_nxt;
    logic           ge1, ge2;
    logic [RW-1:0]  d1, d2, r_sel;

    assign en     = ~v4 | iReady;
    assign oReady = en;
    assign oValid = v4;
    assign oR     = r4;

    assign q1mu  = q1 * MUL;
    assign q3q   = q3 * QL;
    // Only the low K+2 bits matter: the true remainder is below 3Q.
    assign r_nxt = p2 - q3q[RW-1:0];

    assign ge2 = r3 >= Q2R;
    assign ge1 = r3 >= Q1R;
    assign d2  = r3 - Q2R;
    assign d1  = r3 - Q1R;

    always_comb begin
        r_sel = r3;
        if (ge2)
            r_sel = d2;
        else if (ge1)
            r_sel = d1;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            v4 <= 1'b0;
            p1 <= '0;
            p2 <= '0;
            q1 <= '0;
            q3 <= '0;
            r3 <= '0;
            r4 <= '0;
        end else if (en) begin
            v1 <= iValid;
            p1 <= iP[RW-1:0];
            q1 <= iP[PW-1:K-1];
            v2 <= v1;
            p2 <= p1;
            q3 <= q1mu[2*K+1:K+1];
            v3 <= v2;
            r3 <= r_nxt;
            v4 <= v3;
            r4 <= r_sel[K-1:0];
        end
    end

`ifdef BARRETT_RANGE_CHK_EN
    localparam logic [wP-1:0] QQ = wP'(Q) * wP'(Q);

    logic e1, e2, e3, e4;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            e1 <= 1'b0;
            e2 <= 1'b0;
            e3 <= 1'b0;
            e4 <= 1'b0;
        end else if (en) begin
            e1 <= iP >= QQ;
            e2 <= e1;
            e3 <= e2;
            e4 <= e3;
        end
    end

    assign oRangeErr = e4;
`else
    assign oRangeErr = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{iP[wP-1:PW], q1mu[K:0],
                           q3q[2*K:RW], r_sel[RW-1:K]};

endmodule

// File: tb/tb_barrett_reducer.sv
// Directed self-checking bench for barrett_reducer.
// Expected residues are hand-computed constants or P % Q.
module tb_barrett_reducer;

    localparam int QV = 12289;

    logic        iClk;
    logic        iRst_n;
    logic        iValid;
    logic        oReady;
    logic [63:0] iP;
    logic        oValid;
    logic        iReady;
    logic [13:0] oR;
    logic        oRangeErr;

    int tests_run;
    int tests_failed;

    barrett_reducer dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iValid    (iValid),
        .oReady    (oReady),
        .iP        (iP),
        .oValid    (oValid),
        .iReady    (iReady),
        .oR        (oR),
        .oRangeErr (oRangeErr)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

`ifdef BARRETT_RANGE_CHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    task automatic test_reset();
        #1;
        tests_run++;
        if (oValid !== 1'b0 || oR !== 14'd0 || oRangeErr !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: oValid=%b oR=%0d err=%b, want 0/0/0",
                     oValid, oR, oRangeErr);
        end
        @(negedge iClk);
        iRst_n = 1'b1;
        #1;
        tests_run++;
        if (oReady !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: oReady=%b, want 1", oReady);
        end
    endtask

    task automatic test_single();
        @(negedge iClk);
        iReady = 1'b1;
        iValid = 1'b1;
        iP     = 64'd100000;
        for (int i = 1; i <= 4; i++) begin
            @(posedge iClk);
            #1;
            iValid = 1'b0;
            tests_run++;
            if (oValid !== (i == 4)) begin
                tests_failed++;
                $display("FAIL single_latency edge %0d: oValid=%b, want %b",
                         i, oValid, (i == 4));
            end
        end
        tests_run++;
        if (oR !== 14'd1688 || oRangeErr !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_value: oR=%0d err=%b, want 1688/0",
                     oR, oRangeErr);
        end
        repeat (2) @(negedge iClk);
    endtask

    task automatic test_boundary();
        logic [63:0] vin [4];
        logic [13:0] vexp [4];
        vin[0] = 64'd0;         vexp[0] = 14'd0;
        vin[1] = 64'd12289;     vexp[1] = 14'd0;
        vin[2] = 64'd12288;     vexp[2] = 14'd12288;
        vin[3] = 64'd151019520; vexp[3] = 14'd12288;
        iReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge iClk);
            iValid = 1'b1;
            iP     = vin[i];
        end
        @(negedge iClk);
        iValid = 1'b0;
        for (int c = 0; c < 20 && !oValid; c++) @(negedge iClk);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (oValid !== 1'b1 || oR !== vexp[i]) begin
                tests_failed++;
                $display("FAIL boundary[%0d]: oValid=%b oR=%0d, want 1/%0d",
                         i, oValid, oR, vexp[i]);
            end
            @(negedge iClk);
        end
        tests_run++;
        if (oValid !== 1'b0) begin
            tests_failed++;
            $display("FAIL boundary_tail: oValid=%b, want 0", oValid);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] vin [8];
        logic [13:0] vexp [8];
        logic [15:0] pat;
        int          nin, nout, cyc;
        logic        held;
        logic [13:0] held_r;
        vin[0] = 64'd36874;     vexp[0] = 14'd7;
        vin[1] = 64'd1229400;   vexp[1] = 14'd500;
        vin[2] = 64'd151019232; vexp[2] = 14'd12000;
        vin[3] = 64'd1;         vexp[3] = 14'd1;
        vin[4] = 64'd61445042;  vexp[4] = 14'd42;
        vin[5] = 64'd9560841;   vexp[5] = 14'd12288;
        vin[6] = 64'd65535;     vexp[6] = 14'd4090;
        vin[7] = 64'd24580;     vexp[7] = 14'd2;
        pat    = 16'b1011_0010_0101_0110;
        nin    = 0;
        nout   = 0;
        cyc    = 0;
        held   = 1'b0;
        held_r = '0;
        while (nout < 8 && cyc < 200) begin
            @(negedge iClk);
            if (held) begin
                tests_run++;
                if (oValid !== 1'b1 || oR !== held_r) begin
                    tests_failed++;
                    $display("FAIL bp_hold: oValid=%b oR=%0d, want 1/%0d",
                             oValid, oR, held_r);
                end
            end
            iReady = pat[cyc%16];
            iValid = (nin < 8);
            iP     = (nin < 8) ? vin[nin] : 64'd0;
            #1;
            tests_run++;
            if (oReady !== (~oValid | iReady)) begin
                tests_failed++;
                $display("FAIL bp_ready: oReady=%b, want %b",
                         oReady, (~oValid | iReady));
            end
            if (oValid && iReady) begin
                tests_run++;
                if (oR !== vexp[nout]) begin
                    tests_failed++;
                    $display("FAIL bp_result[%0d]: oR=%0d, want %0d",
                             nout, oR, vexp[nout]);
                end
                nout++;
            end
            if (iValid && oReady) nin++;
            held   = oValid && !iReady;
            held_r = oR;
            cyc++;
        end
        tests_run++;
        if (nout != 8) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d results, want 8", nout);
        end
        @(negedge iClk);
        iValid = 1'b0;
        iReady = 1'b1;
        repeat (6) @(negedge iClk);
    endtask

    task automatic test_reset_inflight();
        int stale;
        iReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge iClk);
            iValid = 1'b1;
            iP     = 64'd40000 + 64'(i);
        end
        @(posedge iClk);
        #2;
        iValid = 1'b0;
        iRst_n = 1'b0;
        #1;
        tests_run++;
        if (oValid !== 1'b0 || oR !== 14'd0) begin
            tests_failed++;
            $display("FAIL rst_async: oValid=%b oR=%0d, want 0/0", oValid, oR);
        end
        @(negedge iClk);
        iRst_n = 1'b1;
        stale = 0;
        repeat (8) begin
            @(negedge iClk);
            if (oValid !== 1'b0) stale++;
        end
        tests_run++;
        if (stale != 0) begin
            tests_failed++;
            $display("FAIL rst_stale: %0d cycles with oValid, want 0", stale);
        end
        iValid = 1'b1;
        iP     = 64'd7;
        for (int i = 1; i <= 4; i++) begin
            @(posedge iClk);
            #1;
            iValid = 1'b0;
        end
        tests_run++;
        if (oValid !== 1'b1 || oR !== 14'd7) begin
            tests_failed++;
            $display("FAIL rst_after: oValid=%b oR=%0d, want 1/7", oValid, oR);
        end
        repeat (2) @(negedge iClk);
    endtask

    task automatic test_range();
        iReady = 1'b1;
        @(negedge iClk);
        iValid = 1'b1;
        iP     = 64'd151019521;
        @(negedge iClk);
        iP     = 64'd5;
        @(negedge iClk);
        iValid = 1'b0;
        for (int c = 0; c < 20 && !oValid; c++) @(negedge iClk);
        tests_run++;
        if (oValid !== 1'b1 || oRangeErr !== ERR_EXP) begin
            tests_failed++;
            $display("FAIL range_flag: oValid=%b err=%b, want 1/%b",
                     oValid, oRangeErr, ERR_EXP);
        end
        @(negedge iClk);
        tests_run++;
        if (oValid !== 1'b1 || oR !== 14'd5 || oRangeErr !== 1'b0) begin
            tests_failed++;
            $display("FAIL range_next: oValid=%b oR=%0d err=%b, want 1/5/0",
                     oValid, oR, oRangeErr);
        end
        repeat (3) @(negedge iClk);
    endtask

    task automatic test_random();
        logic [13:0] q[$];
        int          sent, got, cyc, bad;
        logic [63:0] p;
        sent = 0;
        got  = 0;
        cyc  = 0;
        bad  = 0;
        while ((sent < 3000 || q.size() != 0) && cyc < 30000) begin
            @(negedge iClk);
            iReady = ($urandom_range(9, 0) < 7);
            iValid = (sent < 3000) && ($urandom_range(3, 0) != 0);
            p      = 64'($urandom_range(151019520, 0));
            iP     = p;
            #1;
            if (oValid && iReady) begin
                tests_run++;
                if (q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rand_extra: unexpected result oR=%0d", oR);
                end else begin
                    if (oR !== q[0] || oRangeErr !== 1'b0) begin
                        tests_failed++;
                        bad++;
                        if (bad < 5)
                            $display("FAIL rand[%0d]: oR=%0d err=%b, want %0d/0",
                                     got, oR, oRangeErr, q[0]);
                    end
                    void'(q.pop_front());
                end
                got++;
            end
            if (iValid && oReady) begin
                q.push_back(14'(p % 64'(QV)));
                sent++;
            end
            cyc++;
        end
        iValid = 1'b0;
        tests_run++;
        if (got != 3000 || sent != 3000) begin
            tests_failed++;
            $display("FAIL rand_count: sent=%0d got=%0d, want 3000/3000",
                     sent, got);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        iRst_n = 1'b0;
        iValid = 1'b0;
        iReady = 1'b1;
        iP     = '0;
        test_reset();
        test_single();
        test_boundary();
        test_backpressure();
        test_reset_inflight();
        test_range();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
